// File: rtl/placar_partida.sv
// placar_partida: rock-paper-scissors match scorekeeper fed by the round judge
module placar_partida #(
  parameter int CW            = 4,
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_INVALID   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          res_valid,
  input  logic          res_s1,
  input  logic          res_s2,
  output logic          ready,
  output logic [CW-1:0] score_a,
  output logic [CW-1:0] score_b,
  output logic [CW-1:0] rounds,
  output logic [CW-1:0] invalid_count,
  output logic [1:0]    winner,
  output logic          match_done,
  output logic [1:0]    state
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} st_t;
  localparam logic [CW-1:0] WT = CW'(WINS_TO_MATCH);
  localparam logic [CW-1:0] IT = CW'(MAX_INVALID);
  st_t st_q, st_d;
  logic [CW-1:0] a_q, a_d, b_q, b_d, r_q, r_d, i_q, i_d;
  logic [CW-1:0] a_n, b_n, r_n, i_n;
  logic [1:0] w_q, w_d;
  logic md_q, md_d, acc;
  // decode the accepted verdict, then pick next state and counters from post-increment values
  always_comb begin
    acc = (st_q == PLAY) & res_valid & ~start;
    a_n = a_q + CW'(acc & res_s1 & ~res_s2);
    b_n = b_q + CW'(acc & ~res_s1 & res_s2);
    i_n = i_q + CW'(acc & ~res_s1 & ~res_s2);
    r_n = r_q + CW'(acc & (res_s1 | res_s2) & (r_q != '1));
    st_d = st_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    i_d = i_q;
    w_d = w_q;
    md_d = 1'b0;
    case (st_q)
      IDLE, DONE: begin
        if (start) begin
          st_d = PLAY;
          a_d = '0;
          b_d = '0;
          r_d = '0;
          i_d = '0;
          w_d = 2'b00;
        end
      end
      PLAY: begin
        if (start) begin
          a_d = '0;
          b_d = '0;
          r_d = '0;
          i_d = '0;
          w_d = 2'b00;
        end else begin
          a_d = a_n;
          b_d = b_n;
          r_d = r_n;
          i_d = i_n;
          if (acc && a_n == WT) begin
            st_d = DONE;
            w_d = 2'b01;
            md_d = 1'b1;
          end else if (acc && b_n == WT) begin
            st_d = DONE;
            w_d = 2'b10;
            md_d = 1'b1;
          end else if (acc && i_n == IT) begin
            st_d = DONE;
            w_d = 2'b11;
            md_d = 1'b1;
          end
        end
      end
      default: begin
        st_d = IDLE;
        a_d = '0;
        b_d = '0;
        r_d = '0;
        i_d = '0;
        w_d = 2'b00;
      end
    endcase
  end
  // state and score registers; reset clears the match immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      a_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
      i_q  <= '0;
      w_q  <= 2'b00;
      md_q <= 1'b0;
    end else begin
      st_q <= st_d;
      a_q  <= a_d;
      b_q  <= b_d;
      r_q  <= r_d;
      i_q  <= i_d;
      w_q  <= w_d;
      md_q <= md_d;
    end
  end
  assign ready         = (st_q == PLAY);
  assign score_a       = a_q;
  assign score_b       = b_q;
  assign rounds        = r_q;
  assign invalid_count = i_q;
  assign winner        = w_q;
  assign match_done    = md_q;
  assign state         = st_q;
endmodule

// File: tb/tb_placar_partida.sv
// tb_placar_partida: scoreboard bench for the match scorekeeper
module tb_placar_partida;
  typedef struct packed {
    logic [1:0] st;
    logic       rdy;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic [3:0] i;
    logic [1:0] w;
    logic       md;
  } snap_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_valid = 1'b0, res_s1 = 1'b0, res_s2 = 1'b0;
  logic ready, match_done;
  logic [3:0] score_a, score_b, rounds, invalid_count;
  logic [1:0] winner, state;
  int n_vec = 0, n_bad = 0;
  int m_mode = 0, ma = 0, mb = 0, mr = 0, mi = 0, mw = 0;
  bit mdone = 0;
  snap_t exp_q[$];
  placar_partida dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_s1(res_s1), .res_s2(res_s2),
    .ready(ready), .score_a(score_a), .score_b(score_b), .rounds(rounds),
    .invalid_count(invalid_count), .winner(winner), .match_done(match_done), .state(state)
  );
  always #5 clk = ~clk;
  function automatic snap_t dut_snap();
    return '{state, ready, score_a, score_b, rounds, invalid_count, winner, match_done};
  endfunction
  function automatic snap_t model_snap();
    return '{2'(m_mode), m_mode == 1, 4'(ma), 4'(mb), 4'(mr), 4'(mi), 2'(mw), mdone};
  endfunction
  task automatic check(input string nm, input snap_t got, input snap_t want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got st=%b rdy=%b a=%0d b=%0d r=%0d i=%0d w=%b md=%b want st=%b rdy=%b a=%0d b=%0d r=%0d i=%0d w=%b md=%b",
        nm, $time, got.st, got.rdy, got.a, got.b, got.r, got.i, got.w, got.md,
        want.st, want.rdy, want.a, want.b, want.r, want.i, want.w, want.md);
    end
  endtask
  task automatic model_clear();
    m_mode = 0; ma = 0; mb = 0; mr = 0; mi = 0; mw = 0; mdone = 0;
  endtask
  // one clock of stimulus: drive inputs, advance the match rules, queue the expected result
  task automatic cyc(input bit st, input bit v, input bit s1, input bit s2);
    @(negedge clk);
    start = st; res_valid = v; res_s1 = s1; res_s2 = s2;
    mdone = 0;
    if (st) begin
      m_mode = 1; ma = 0; mb = 0; mr = 0; mi = 0; mw = 0;
    end else if (m_mode == 1 && v) begin
      if (s1 || s2) mr = (mr < 15) ? mr + 1 : 15;
      if (s1 && !s2) ma++;
      if (!s1 && s2) mb++;
      if (!s1 && !s2) mi++;
      if (ma == 2) begin m_mode = 2; mw = 1; mdone = 1; end
      else if (mb == 2) begin m_mode = 2; mw = 2; mdone = 1; end
      else if (mi == 2) begin m_mode = 2; mw = 3; mdone = 1; end
    end
    exp_q.push_back(model_snap());
  endtask
  task automatic verdicts(input bit [1:0] v, input bit gap);
    cyc(0, 1, v[1], v[0]);
    if (gap) cyc(0, 0, 1, 0);
  endtask
  // monitor: after each edge compare the DUT against the oldest queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_snap(), exp_q.pop_front());
    end
  end
  initial begin
    #1;
    check("reset", dut_snap(), '0);
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    verdicts(2'b10, 0);
    verdicts(2'b10, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    verdicts(2'b11, 1);
    verdicts(2'b01, 1);
    verdicts(2'b11, 1);
    verdicts(2'b01, 1);
    cyc(1, 0, 0, 0);
    verdicts(2'b00, 0);
    verdicts(2'b10, 0);
    verdicts(2'b00, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    verdicts(2'b10, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    verdicts(2'b01, 0);
    @(negedge clk);
    #2 rst = 1;
    #1 check("async_reset", dut_snap(), '0);
    model_clear();
    @(negedge clk);
    check("held_reset", dut_snap(), '0);
    rst = 0;
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 0);
    verdicts(2'b01, 0);
    verdicts(2'b01, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) verdicts(2'b11, k[0]);
    verdicts(2'b00, 0);
    verdicts(2'b10, 0);
    verdicts(2'b10, 0);
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom));
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
